// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter for the single ext_sram valid/ready port, with a bounded
// port-1 burst lock. Define SRAM_ARB_TIMEOUT_EN to add the BUSY timeout and timeout_err port.
module sram_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_valid,
  input  logic              m0_rw,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_dtw,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_dtr,
  input  logic              m1_valid,
  input  logic              m1_rw,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_dtw,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_dtr,
  input  logic              m1_lock,
  output logic              sval,
  output logic              srw,
  output logic [ADDR_W-1:0] saddr,
  output logic [DATA_W-1:0] sdtw,
  input  logic [DATA_W-1:0] sdtr,
  input  logic              srdy,
  output logic [1:0]        grant
`ifdef SRAM_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  if (MAX_BURST < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("sram_arbiter: MAX_BURST and TIMEOUT must be at least 1");
  end

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q;
  logic              sval_q, srw_q, last_q, lock_q;
  logic [ADDR_W-1:0] saddr_q;
  logic [DATA_W-1:0] sdtw_q;
  logic [1:0]        grant_q;
  logic [BW-1:0]     burst_q;
  logic [BW:0]       burst_inc;
  logic              pick_m1, tmo, done;
  logic [DATA_W-1:0] rdata;

`ifdef SRAM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] age_q;

  always_comb tmo = (state_q == BUSY) && !srdy && (age_q == TW'(TIMEOUT - 1));
  assign timeout_err = tmo;
`else
  always_comb tmo = 1'b0;
`endif

  // Port 1 wins when locked, when alone, or when port 0 was served last.
  always_comb begin
    pick_m1   = m1_valid && (lock_q || !m0_valid || !last_q);
    burst_inc = {1'b0, burst_q} + 1'b1;
    done      = (state_q == BUSY) && (srdy || tmo);
    rdata     = srdy ? sdtr : '1;
    m0_ready  = done && grant_q[0];
    m1_ready  = done && grant_q[1];
    m0_dtr    = m0_ready ? rdata : '0;
    m1_dtr    = m1_ready ? rdata : '0;
  end

  assign sval  = sval_q;
  assign srw   = srw_q;
  assign saddr = saddr_q;
  assign sdtw  = sdtw_q;
  assign grant = grant_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sval_q  <= 1'b0;
      srw_q   <= 1'b0;
      saddr_q <= '0;
      sdtw_q  <= '0;
      grant_q <= '0;
      last_q  <= 1'b1;
      lock_q  <= 1'b0;
      burst_q <= '0;
`ifdef SRAM_ARB_TIMEOUT_EN
      age_q   <= '0;
`endif
    end else begin
      if (state_q == IDLE) begin
        if (m0_valid || m1_valid) begin
          state_q <= BUSY;
          sval_q  <= 1'b1;
          if (pick_m1) begin
            grant_q <= 2'b10;
            srw_q   <= m1_rw;
            saddr_q <= m1_addr;
            sdtw_q  <= m1_dtw;
          end else begin
            grant_q <= 2'b01;
            srw_q   <= m0_rw;
            saddr_q <= m0_addr;
            sdtw_q  <= m0_dtw;
            lock_q  <= 1'b0;
            burst_q <= '0;
          end
        end
      end else if (done) begin
        state_q <= IDLE;
        sval_q  <= 1'b0;
        grant_q <= '0;
        last_q  <= grant_q[1];
        // Lock is sampled only as a port-1 transfer completes.
        if (grant_q[1]) begin
          if (m1_lock && m1_valid && (burst_inc < (BW + 1)'(MAX_BURST))) begin
            lock_q  <= 1'b1;
            burst_q <= burst_inc[BW-1:0];
          end else begin
            lock_q  <= 1'b0;
            burst_q <= '0;
          end
        end
      end
`ifdef SRAM_ARB_TIMEOUT_EN
      age_q <= (state_q == BUSY && !done) ? age_q + 1'b1 : '0;
`endif
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic against a
// transaction-level arbitration/memory model. Honours SRAM_ARB_TIMEOUT_EN.
module tb_sram_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MB = 4;
  localparam int unsigned TO = 8;
`ifdef SRAM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic m0_valid, m0_rw, m0_ready, m1_valid, m1_rw, m1_ready, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr, saddr;
  logic [DW-1:0] m0_dtw, m0_dtr, m1_dtw, m1_dtr, sdtw, sdtr;
  logic sval, srw, srdy;
  logic [1:0] grant;
  logic tmo_obs;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_dtw(m0_dtw),
    .m0_ready(m0_ready), .m0_dtr(m0_dtr),
    .m1_valid(m1_valid), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_dtw(m1_dtw),
    .m1_ready(m1_ready), .m1_dtr(m1_dtr), .m1_lock(m1_lock),
    .sval(sval), .srw(srw), .saddr(saddr), .sdtw(sdtw), .sdtr(sdtr), .srdy(srdy),
    .grant(grant)
`ifdef SRAM_ARB_TIMEOUT_EN
    , .timeout_err(tmo_obs)
`endif
  );
`ifndef SRAM_ARB_TIMEOUT_EN
  assign tmo_obs = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Master-side stimulus
  logic [1:0]    rq_v, rq_rw, ready_seen;
  logic [AW-1:0] rq_addr [2];
  logic [DW-1:0] rq_dtw [2];
  logic          rq_lock;
  int unsigned   req_pct, renew_pct, lock_pct;

  // ext_sram responder
  logic [DW-1:0] sram_mem [16];
  bit            rsp_en, rsp_rand;
  int unsigned   rsp_lat, rsp_cnt, stray_pct;

  // Reference model: who owns the port, what it latched, arbitration history
  logic [DW-1:0] ref_mem [16];
  bit            m_busy, m_last, m_lock, m_rw;
  int            m_owner, m_burst, m_age;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dtw;

  // Observations for directed checks
  logic [1:0]    dut_glog [$];
  logic          prev_sval;
  int            cycle_no, rdy_cyc, rise_cyc, n_sval;
  logic [DW-1:0] rdy_dtr;
  logic [AW-1:0] rdy_saddr;
  logic [DW-1:0] rdy_sdtw;
  logic          rdy_tmo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_pins();
    m0_valid = rq_v[0]; m0_rw = rq_rw[0]; m0_addr = rq_addr[0]; m0_dtw = rq_dtw[0];
    m1_valid = rq_v[1]; m1_rw = rq_rw[1]; m1_addr = rq_addr[1]; m1_dtw = rq_dtw[1];
    m1_lock  = rq_lock;
  endtask

  task automatic new_req(input int p);
    rq_v[p]    = 1'b1;
    rq_rw[p]   = 1'($urandom_range(1));
    rq_addr[p] = $urandom;
    rq_dtw[p]  = $urandom;
    if (p == 1) rq_lock = ($urandom_range(99) < lock_pct);
  endtask

  task automatic master_policy();
    for (int p = 0; p < 2; p++) begin
      if (ready_seen[p]) begin
        ready_seen[p] = 1'b0;
        if ($urandom_range(99) < renew_pct) new_req(p);
        else begin
          rq_v[p] = 1'b0;
          if (p == 1) rq_lock = 1'b0;
        end
      end else if (!rq_v[p] && $urandom_range(99) < req_pct) new_req(p);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_lock = 0; m_burst = 0; m_age = 0; m_owner = 0;
    rsp_cnt = 0; ready_seen = '0; prev_sval = 1'b0; n_sval = 0;
    dut_glog.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rq_v = '0; rq_lock = 1'b0; drive_pins(); srdy = 1'b0;
    #1;
    chk("rst_sval", {31'b0, sval}, 32'd0);
    chk("rst_grant", {30'b0, grant}, 32'd0);
    chk("rst_saddr", saddr, 32'd0);
    chk("rst_sdtw", sdtw, 32'd0);
    chk("rst_ready", {30'b0, m1_ready, m0_ready}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One clock: drive at posedge+1, sample and compare at negedge, then advance the model.
  task automatic cycle();
    bit fin, tmo;
    int w;
    logic [DW-1:0] exp_dtr, obs_dtr;
    cycle_no++;
    @(posedge clk); #1;
    srdy = 1'b0;
    sdtr = $urandom;
    if (sval === 1'b1 && rsp_en && rsp_cnt == rsp_lat) begin
      srdy = 1'b1;
      if (srw) sram_mem[saddr[5:2]] = sdtw;
      else     sdtr = sram_mem[saddr[5:2]];
    end else if (sval !== 1'b1 && $urandom_range(99) < stray_pct) srdy = 1'b1;
    drive_pins();
    @(negedge clk);
    tmo = TMO_EN && m_busy && !srdy && (m_age == int'(TO) - 1);
    fin = m_busy && (srdy || tmo);
    chk("sval", {31'b0, sval}, {31'b0, m_busy});
    chk("grant", {30'b0, grant}, !m_busy ? 32'd0 : (m_owner == 1) ? 32'd2 : 32'd1);
    if (m_busy) begin
      chk("saddr", saddr, m_addr);
      chk("srw", {31'b0, srw}, {31'b0, m_rw});
      chk("sdtw", sdtw, m_dtw);
    end
    chk("m0_ready", {31'b0, m0_ready}, {31'b0, fin && m_owner == 0});
    chk("m1_ready", {31'b0, m1_ready}, {31'b0, fin && m_owner == 1});
    chk("timeout_err", {31'b0, tmo_obs}, {31'b0, tmo});
    if (sval === 1'b1) n_sval++;
    if (sval === 1'b1 && prev_sval !== 1'b1) begin
      dut_glog.push_back(grant);
      rise_cyc = cycle_no;
    end
    prev_sval = sval;
    if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
      rdy_cyc = cycle_no; rdy_saddr = saddr; rdy_sdtw = sdtw; rdy_tmo = tmo_obs;
      rdy_dtr = (m1_ready === 1'b1) ? m1_dtr : m0_dtr;
    end
    if (fin) begin
      exp_dtr = tmo ? '1 : (m_rw ? sdtr : ref_mem[m_addr[5:2]]);
      obs_dtr = (m_owner == 1) ? m1_dtr : m0_dtr;
      chk("dtr", obs_dtr, exp_dtr);
      if (m_rw && !tmo) ref_mem[m_addr[5:2]] = m_dtw;
      ready_seen[m_owner] = 1'b1;
      if (m_owner == 1) begin
        if (rq_lock && rq_v[1] && m_burst + 1 < int'(MB)) begin m_lock = 1; m_burst++; end
        else begin m_lock = 0; m_burst = 0; end
      end
      m_last = (m_owner == 1);
      m_busy = 0;
    end else if (m_busy) begin
      m_age++;
    end else if (rq_v != 2'b00) begin
      if (rq_v == 2'b01)      w = 0;
      else if (rq_v == 2'b10) w = 1;
      else if (m_lock)        w = 1;
      else                    w = m_last ? 0 : 1;
      if (w == 0) begin m_lock = 0; m_burst = 0; end
      m_owner = w; m_rw = rq_rw[w]; m_addr = rq_addr[w]; m_dtw = rq_dtw[w];
      m_busy = 1; m_age = 0;
    end
    if (sval !== 1'b1) rsp_cnt = 0;
    else if (srdy) begin
      rsp_cnt = 0;
      if (rsp_rand) rsp_lat = $urandom_range(0, 3);
    end else rsp_cnt++;
  endtask

  logic [1:0] exp2 [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] exp3 [7] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

  initial begin
    int c0;
    logic [1:0] g;
    cycle_no = 0; rdy_cyc = 0; rise_cyc = 0;
    rq_rw = '0; rq_addr[0] = '0; rq_addr[1] = '0; rq_dtw[0] = '0; rq_dtw[1] = '0;
    sdtr = '0;
    for (int i = 0; i < 16; i++) begin
      sram_mem[i] = $urandom;
      ref_mem[i]  = sram_mem[i];
    end
    sram_mem[0] = 32'h1234_5678; ref_mem[0] = 32'h1234_5678;
    rsp_en = 1; rsp_rand = 0; rsp_lat = 3; stray_pct = 0;
    req_pct = 0; renew_pct = 0; lock_pct = 0;

    // 1: single m0 read, SRAM latency 3
    do_reset();
    rq_v[0] = 1'b1; rq_rw[0] = 1'b0; rq_addr[0] = 32'h100; rq_dtw[0] = '0;
    c0 = cycle_no; rdy_cyc = 0;
    for (int i = 0; i < 12; i++) begin master_policy(); cycle(); end
    chk("t1_sval_delay", rise_cyc - c0, 32'd2);
    chk("t1_ready_delay", rdy_cyc - c0, 32'd5);
    chk("t1_dtr", rdy_dtr, 32'h1234_5678);

    // 2: both masters continuously requesting alternate
    do_reset();
    rsp_rand = 1; req_pct = 100; renew_pct = 100; lock_pct = 0;
    new_req(0); new_req(1);
    for (int i = 0; i < 80 && dut_glog.size() < 4; i++) begin master_policy(); cycle(); end
    for (int i = 0; i < 4; i++) begin
      g = (i < dut_glog.size()) ? dut_glog[i] : 2'bxx;
      chk($sformatf("t2_grant%0d", i), {30'b0, g}, {30'b0, exp2[i]});
    end

    // 3: port 1 burst lock against a waiting port 0
    do_reset();
    lock_pct = 100;
    new_req(0); new_req(1);
    for (int i = 0; i < 150 && dut_glog.size() < 7; i++) begin master_policy(); cycle(); end
    for (int i = 0; i < 7; i++) begin
      g = (i < dut_glog.size()) ? dut_glog[i] : 2'bxx;
      chk($sformatf("t3_grant%0d", i), {30'b0, g}, {30'b0, exp3[i]});
    end

    // 4: latched write survives master-side changes, then read it back
    do_reset();
    rsp_rand = 0; rsp_lat = 4; req_pct = 0; renew_pct = 0; lock_pct = 0;
    rq_v[0] = 1'b1; rq_rw[0] = 1'b1; rq_addr[0] = 32'h40; rq_dtw[0] = 32'hCAFE_F00D;
    for (int i = 0; i < 12; i++) begin
      master_policy();
      if (i > 0 && rq_v[0]) begin rq_addr[0] = $urandom; rq_dtw[0] = $urandom; end
      cycle();
    end
    chk("t4_saddr", rdy_saddr, 32'h40);
    chk("t4_sdtw", rdy_sdtw, 32'hCAFE_F00D);
    rq_v[0] = 1'b1; rq_rw[0] = 1'b0; rq_addr[0] = 32'h40;
    for (int i = 0; i < 12; i++) begin master_policy(); cycle(); end
    chk("t4_readback", rdy_dtr, 32'hCAFE_F00D);

    // 5: asynchronous reset in the middle of a transfer
    do_reset();
    rsp_lat = 20;
    rq_v[0] = 1'b1; rq_rw[0] = 1'b0; rq_addr[0] = 32'h8;
    repeat (3) cycle();
    @(posedge clk); #1;
    chk("t5_busy", {31'b0, sval}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_sval", {31'b0, sval}, 32'd0);
    chk("t5_async_grant", {30'b0, grant}, 32'd0);
    rq_v = '0; drive_pins(); srdy = 1'b0;
    model_reset();
    @(posedge clk); #1 reset_n = 1'b1;
    stray_pct = 100; rdy_cyc = 0; c0 = cycle_no;
    repeat (4) cycle();
    chk("t5_no_ready", rdy_cyc, 32'd0);
    stray_pct = 0;

`ifdef SRAM_ARB_TIMEOUT_EN
    // 6: SRAM never answers
    do_reset();
    rsp_en = 0; renew_pct = 0;
    rq_v[0] = 1'b1; rq_rw[0] = 1'b0; rq_addr[0] = 32'h20;
    rdy_cyc = 0; rdy_tmo = 1'b0;
    for (int i = 0; i < 20 && rdy_cyc == 0; i++) begin master_policy(); cycle(); end
    chk("t6_busy_cycles", n_sval, 32'd8);
    chk("t6_timeout_err", {31'b0, rdy_tmo}, 32'd1);
    chk("t6_dtr", rdy_dtr, 32'hFFFF_FFFF);
    master_policy(); stray_pct = 100;
    repeat (4) cycle();
    stray_pct = 0; rsp_en = 1;
`endif

    // Randomized traffic: mixed latency, stray srdy, varying lock pressure
    do_reset();
    rsp_rand = 1; rsp_lat = 1; stray_pct = 20;
    req_pct = 60; renew_pct = 50; lock_pct = 40;
    repeat (1500) begin master_policy(); cycle(); end
    lock_pct = 90; req_pct = 90; renew_pct = 80;
    repeat (1500) begin master_policy(); cycle(); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
